uart_frame_decoder: RTL and testbench

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

---
 rtl/uart_frame_decoder.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder.sv
// UART receive-frame decoder: start/data/[parity]/stop checking on an oversampled rx line.
// Latency: verdict pulse one cycle after the edge that samples the last (or first failing) stop bit.
// Backpressure: none; one pulse per frame, data_out holds the last good frame until the next one.
//
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   rx                  - asynchronous serial input, idle high
//   detect_only         - suspends decoding (FSM held in IDLE, pulses low)
//   parity_odd          - parity sense (1 = odd, 0 = even), used only with parity compiled in
//   data_out            - last good frame, LSB = first data bit received
//   out_valid           - one-cycle pulse, data_out updated together with it
//   frame_err           - one-cycle pulse on a stop bit read as 0
//   parity_err          - one-cycle pulse on parity mismatch (tied 0 without parity)
//   busy                - FSM not in IDLE
// Build option: define UART_FRAME_DECODER_PARITY_EN to add one parity bit after the data bits.

module uart_frame_decoder #(
    parameter int CLK_PER_BIT = 10,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 detect_only,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 out_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_FRAME_DECODER_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    localparam int            CW        = 16;
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_PER_BIT - 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    // Registered state
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_rx_prev;
    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_out_valid;
    logic                 r_frame_err;

    // Next-state values
    state_t               w_state_nxt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [2:0]           w_bit_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] w_data_nxt;
    logic                 w_valid_nxt;
    logic                 w_ferr_nxt;

    logic                 w_rx_s;
    logic                 w_fall;
    logic                 w_tick;

`ifdef UART_FRAME_DECODER_PARITY_EN
    logic                 r_parity_err;
    logic                 r_par_acc;
    logic                 r_par_bad;
    logic                 w_perr_nxt;
    logic                 w_par_acc_nxt;
    logic                 w_par_bad_nxt;
`else
    logic                 w_unused_parity_odd;
    assign w_unused_parity_odd = parity_odd;
`endif

    assign w_rx_s = r_sync2;
    // A start needs a genuine 1->0 transition, so a line stuck low after a
    // frame error (break) cannot re-trigger until it has been seen high.
    assign w_fall = r_rx_prev & ~r_sync2;
    assign w_tick = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_FRAME_DECODER_PARITY_EN
        w_perr_nxt    = 1'b0;
        w_par_acc_nxt = r_par_acc;
        w_par_bad_nxt = r_par_bad;
`endif
        if (detect_only) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        w_state_nxt = S_START;
                        w_cnt_nxt   = HALF_LOAD;
                        w_bit_nxt   = '0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        // Line back high at mid start bit: treat as a glitch.
                        if (w_rx_s) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_DATA;
                            w_cnt_nxt   = FULL_LOAD;
                            w_bit_nxt   = '0;
`ifdef UART_FRAME_DECODER_PARITY_EN
                            w_par_acc_nxt = 1'b0;
`endif
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_cnt_nxt   = FULL_LOAD;
`ifdef UART_FRAME_DECODER_PARITY_EN
                        w_par_acc_nxt = r_par_acc ^ w_rx_s;
`endif
                        if (r_bit_idx == LAST_DATA) begin
                            w_bit_nxt = '0;
`ifdef UART_FRAME_DECODER_PARITY_EN
                            w_state_nxt = S_PARITY;
`else
                            w_state_nxt = S_STOP;
`endif
                        end else begin
                            w_bit_nxt = r_bit_idx + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
`ifdef UART_FRAME_DECODER_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        // Data XOR parity bit must equal the selected sense.
                        w_par_bad_nxt = (r_par_acc ^ w_rx_s) != parity_odd;
                        w_cnt_nxt     = FULL_LOAD;
                        w_bit_nxt     = '0;
                        w_state_nxt   = S_STOP;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        if (!w_rx_s) begin
                            // Framing error outranks parity; stop at the first bad stop bit.
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else if (r_bit_idx == LAST_STOP) begin
                            w_state_nxt = S_IDLE;
`ifdef UART_FRAME_DECODER_PARITY_EN
                            if (r_par_bad) begin
                                w_perr_nxt = 1'b1;
                            end else begin
                                w_valid_nxt = 1'b1;
                                w_data_nxt  = r_shift;
                            end
`else
                            w_valid_nxt = 1'b1;
                            w_data_nxt  = r_shift;
`endif
                        end else begin
                            w_bit_nxt = r_bit_idx + 1'b1;
                            w_cnt_nxt = FULL_LOAD;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_FRAME_DECODER_PARITY_EN
            r_parity_err <= 1'b0;
            r_par_acc    <= 1'b0;
            r_par_bad    <= 1'b0;
`endif
        end else begin
            // Synchronizer keeps running even while decoding is suspended.
            r_sync1     <= rx;
            r_sync2     <= r_sync1;
            r_rx_prev   <= r_sync2;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_out_valid <= w_valid_nxt;
            r_frame_err <= w_ferr_nxt;
`ifdef UART_FRAME_DECODER_PARITY_EN
            r_parity_err <= w_perr_nxt;
            r_par_acc    <= w_par_acc_nxt;
            r_par_bad    <= w_par_bad_nxt;
`endif
        end
    end

    assign data_out  = r_data;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != S_IDLE);
`ifdef UART_FRAME_DECODER_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_decoder.sv
module tb_uart_frame_decoder;

    localparam int C = 10;
`ifdef UART_FRAME_DECODER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rx0, rx1, det0, det1, podd;
    logic [7:0] dout0;
    logic       val0, fe0, pe0, busy0;
    logic [4:0] dout1;
    logic       val1, fe1, pe1, busy1;

    uart_frame_decoder dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .detect_only(det0), .parity_odd(podd),
        .data_out(dout0), .out_valid(val0), .frame_err(fe0), .parity_err(pe0), .busy(busy0)
    );

    uart_frame_decoder #(.CLK_PER_BIT(C), .DATA_BITS(5), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .detect_only(det1), .parity_odd(podd),
        .data_out(dout1), .out_valid(val1), .frame_err(fe1), .parity_err(pe1), .busy(busy1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = good frame, 1 = framing error, 2 = parity error
    typedef struct {
        int         kind;
        logic [7:0] dat;
        int         at;
        logic       bsy;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    always @(negedge clk) begin
        if (val0) q0.push_back('{0, dout0, cyc, busy0});
        if (fe0)  q0.push_back('{1, dout0, cyc, busy0});
        if (pe0)  q0.push_back('{2, dout0, cyc, busy0});
        if (val1) q1.push_back('{0, {3'b000, dout1}, cyc, busy1});
        if (fe1)  q1.push_back('{1, {3'b000, dout1}, cyc, busy1});
        if (pe1)  q1.push_back('{2, {3'b000, dout1}, cyc, busy1});
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Correct parity bit for the data under the given sense.
    function automatic bit good_par(input logic [7:0] d, input int nd, input bit odd);
        bit p;
        p = odd;
        for (int i = 0; i < nd; i++) p ^= d[i];
        return p;
    endfunction

    // Reference verdict from the frame contents alone.
    function automatic int model_kind(input logic [7:0] d, input int nd, input bit stop_ok,
                                      input bit pbit, input bit odd);
        if (!stop_ok) return 1;
        if (PAR != 0 && pbit != good_par(d, nd, odd)) return 2;
        return 0;
    endfunction

    // Serial transmitter: start, data LSB first, optional parity, stop bits.
    task automatic tx(input int sel, input logic [7:0] d, input int nd, input int ns,
                      input bit stop_val, input bit pbit, input int abort_at);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) bits.push_back(d[i]);
        if (PAR != 0) bits.push_back(pbit);
        for (int i = 0; i < ns; i++) bits.push_back(stop_val);
        for (int c = 0; c < bits.size() * C; c++) begin
            if (c == abort_at) break;
            @(negedge clk);
            if (sel == 0) rx0 = bits[c / C];
            else          rx1 = bits[c / C];
        end
    endtask

    task automatic idle(input int sel, input int n);
        repeat (n) begin
            @(negedge clk);
            if (sel == 0) rx0 = 1'b1;
            else          rx1 = 1'b1;
        end
    endtask

    typedef struct {
        logic [7:0] d;
        bit         stop_ok;
        bit         pflip;
        int         kind;
        logic [7:0] dexp;
    } vec_t;

    vec_t vt[6];
    ev_t  expq[$];

    initial begin
        #900000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int         bh;
        logic [7:0] last_good;

        vt[0] = '{8'hA5, 1'b1, 1'b0, 0, 8'hA5};
        vt[1] = '{8'h3C, 1'b0, 1'b0, 1, 8'hA5};
        vt[2] = '{8'h00, 1'b1, 1'b0, 0, 8'h00};
        vt[3] = '{8'hFF, 1'b1, 1'b0, 0, 8'hFF};
`ifdef UART_FRAME_DECODER_PARITY_EN
        vt[4] = '{8'h81, 1'b1, 1'b1, 2, 8'hFF};
`else
        vt[4] = '{8'h81, 1'b1, 1'b1, 0, 8'h81};
`endif
        vt[5] = '{8'h81, 1'b1, 1'b0, 0, 8'h81};

        // Reset state
        rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; det0 = 1'b0; det1 = 1'b0; podd = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_data_out", 32'(dout0), 0);
        chk("rst_out_valid", 32'(val0), 0);
        chk("rst_frame_err", 32'(fe0), 0);
        chk("rst_parity_err", 32'(pe0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_data_out_5b", 32'(dout1), 0);
        rst_n = 1'b1;
        idle(0, 5);

        // Directed table
        for (int v = 0; v < 6; v++) begin
            q0.delete();
            tx(0, vt[v].d, 8, 1, vt[v].stop_ok, good_par(vt[v].d, 8, podd) ^ vt[v].pflip, -1);
            if (!vt[v].stop_ok) begin
                // Line held low (break): must not restart.
                bh = 0;
                repeat (30) begin @(negedge clk); if (busy0) bh++; end
                chk("break_no_restart_busy", 32'(bh), 0);
            end
            idle(0, 30);
            chk($sformatf("vec%0d_pulses", v), 32'(q0.size()), 1);
            if (q0.size() >= 1) begin
                chk($sformatf("vec%0d_kind", v), 32'(q0[0].kind), 32'(vt[v].kind));
                chk($sformatf("vec%0d_data_at_pulse", v), 32'(q0[0].dat), 32'(vt[v].dexp));
                chk($sformatf("vec%0d_busy_at_pulse", v), 32'(q0[0].bsy), 0);
            end
            chk($sformatf("vec%0d_data_after", v), 32'(dout0), 32'(vt[v].dexp));
        end

        // 3-cycle low glitch from idle
        q0.delete();
        bh = 0;
        @(negedge clk); rx0 = 1'b0;
        if (busy0) bh++;
        repeat (2) begin @(negedge clk); if (busy0) bh++; end
        @(negedge clk); rx0 = 1'b1;
        if (busy0) bh++;
        repeat (16) begin @(negedge clk); if (busy0) bh++; end
        chk("glitch_busy_seen_and_short", 32'(bh >= 1 && bh <= 5), 1);
        chk("glitch_busy_end", 32'(busy0), 0);
        chk("glitch_no_pulse", 32'(q0.size()), 0);

        // Reset for one clock in the middle of data bit 2
        q0.delete();
        tx(0, 8'hC3, 8, 1, 1'b1, good_par(8'hC3, 8, podd), 35);
        @(negedge clk); rst_n = 1'b0; rx0 = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        chk("midreset_busy_next", 32'(busy0), 0);
        idle(0, 30);
        chk("midreset_no_pulse", 32'(q0.size()), 0);
        chk("midreset_data_cleared", 32'(dout0), 0);
        tx(0, 8'h5A, 8, 1, 1'b1, good_par(8'h5A, 8, podd), -1);
        idle(0, 20);
        chk("post_reset_pulses", 32'(q0.size()), 1);
        if (q0.size() >= 1) begin
            chk("post_reset_kind", 32'(q0[0].kind), 0);
            chk("post_reset_data", 32'(q0[0].dat), 32'h5A);
        end

        // detect_only raised mid-frame
        q0.delete();
        fork
            tx(0, 8'hC3, 8, 1, 1'b1, good_par(8'hC3, 8, podd), -1);
            begin
                repeat (45) @(negedge clk);
                det0 = 1'b1;
                @(negedge clk);
                chk("detect_busy_next", 32'(busy0), 0);
                bh = 0;
                repeat (50) begin @(negedge clk); if (busy0) bh++; end
            end
        join
        chk("detect_busy_held_low", 32'(bh), 0);
        idle(0, 20);
        det0 = 1'b0;
        idle(0, 10);
        chk("detect_no_pulse", 32'(q0.size()), 0);
        chk("detect_data_kept", 32'(dout0), 32'h5A);
        tx(0, 8'h5A, 8, 1, 1'b1, good_par(8'h5A, 8, podd), -1);
        idle(0, 20);
        chk("post_detect_pulses", 32'(q0.size()), 1);
        if (q0.size() >= 1) begin
            chk("post_detect_kind", 32'(q0[0].kind), 0);
            chk("post_detect_data", 32'(q0[0].dat), 32'h5A);
        end

        // 5 data bits, 2 stop bits, back-to-back frames
        q1.delete();
        tx(1, 8'h15, 5, 2, 1'b1, good_par(8'h15, 5, podd), -1);
        tx(1, 8'h0A, 5, 2, 1'b1, good_par(8'h0A, 5, podd), -1);
        idle(1, 30);
        chk("b2b_pulses", 32'(q1.size()), 2);
        if (q1.size() == 2) begin
            chk("b2b_kind0", 32'(q1[0].kind), 0);
            chk("b2b_kind1", 32'(q1[1].kind), 0);
            chk("b2b_data0", 32'(q1[0].dat), 32'h15);
            chk("b2b_data1", 32'(q1[1].dat), 32'h0A);
            // Frames abut, so the verdicts are one frame length apart.
            chk("b2b_spacing", 32'(q1[1].at - q1[0].at), 32'((1 + 5 + PAR + 2) * C));
        end

        // Randomized frames against the reference model
        q0.delete();
        expq.delete();
        last_good = 8'h5A;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            bit         sok, pflip, pb;
            int         k;
            d     = 8'($urandom_range(0, 255));
            sok   = ($urandom_range(0, 4) != 0);
            pflip = ($urandom_range(0, 3) == 0);
            podd  = 1'($urandom_range(0, 1));
            pb    = good_par(d, 8, podd) ^ pflip;
            k     = model_kind(d, 8, sok, pb, podd);
            if (k == 0) last_good = d;
            expq.push_back('{k, last_good, 0, 1'b0});
            tx(0, d, 8, 1, sok, pb, -1);
            if (!sok) idle(0, $urandom_range(2, 20));
            else      idle(0, $urandom_range(0, 20));
        end
        idle(0, 30);
        chk("rand_pulse_count", 32'(q0.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < q0.size(); i++) begin
            chk($sformatf("rand%0d_kind", i), 32'(q0[i].kind), 32'(expq[i].kind));
            chk($sformatf("rand%0d_data", i), 32'(q0[i].dat), 32'(expq[i].dat));
        end
        chk("rand_final_data", 32'(dout0), 32'(last_good));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
